// File: rtl/gc_controller_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : gc_controller_reader_if
// Brief   : Joybus data line plus decoded controller state for the display path
// Revision: 1.0
// ============================================================================
interface gc_controller_reader_if;
  logic       data_in;
  logic       data_oe;
  logic       A, B, X, Y, start_pause;
  logic       L, R, Z;
  logic       D_UP, D_DOWN, D_RIGHT, D_LEFT;
  logic [7:0] stick_x, stick_y, cstick_x, cstick_y, trig_l, trig_r;
  logic       frame_valid;
  logic       connected;

  modport master (
    input  data_in,
    output data_oe,
    output A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT,
    output stick_x, stick_y, cstick_x, cstick_y, trig_l, trig_r,
    output frame_valid, connected
  );

  modport slave (
    output data_in,
    input  data_oe,
    input  A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT,
    input  stick_x, stick_y, cstick_x, cstick_y, trig_l, trig_r,
    input  frame_valid, connected
  );
endinterface
`default_nettype wire

// File: rtl/gc_controller_reader.sv
`default_nettype none
// ============================================================================
// Module  : gc_controller_reader
// Brief   : Joybus master polling one GameCube controller, registered outputs
// Revision: 1.0
// ============================================================================
module gc_controller_reader #(
  parameter int CLK_FREQ_MHZ = 25,
  parameter int POLL_US      = 1000,
  parameter int TIMEOUT_US   = 200
) (
  input  wire logic              clk,
  input  wire logic              reset,
  gc_controller_reader_if.master bus
);
  localparam int US       = CLK_FREQ_MHZ;
  localparam int POLL_CYC = POLL_US * US;
  localparam int TMO_CYC  = TIMEOUT_US * US;
  localparam int WDOG_CYC = 8 * US;
  localparam int MAX_A    = (POLL_CYC > TMO_CYC) ? POLL_CYC : TMO_CYC;
  localparam int MAX_CYC  = (MAX_A > WDOG_CYC) ? MAX_A : WDOG_CYC;
  localparam int TW       = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] POLL_END  = TW'(POLL_CYC - 1);
  localparam logic [TW-1:0] TMO_END   = TW'(TMO_CYC - 1);
  localparam logic [TW-1:0] WDOG_END  = TW'(WDOG_CYC - 1);
  localparam logic [TW-1:0] BIT_END   = TW'(4 * US - 1);
  localparam logic [TW-1:0] SAMPLE_AT = TW'(2 * US - 1);
  localparam logic [TW-1:0] ONE_LOW   = TW'(US);
  localparam logic [TW-1:0] ZERO_LOW  = TW'(3 * US);
  localparam logic [24:0]   POLL_CMD  = {24'h400300, 1'b1};
  localparam logic [6:0]    SEND_LAST = 7'd24;
  localparam logic [6:0]    RECV_LAST = 7'd63;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_RESP = 3'd2,
    RECV      = 3'd3,
    CHECK     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    bit_cnt_q, bit_cnt_d;
  logic [63:0]   resp_q, resp_d;
  logic [24:0]   cmd_q, cmd_d;
  logic          oe_q, oe_d;
  logic [11:0]   btn_q, btn_d;
  logic [47:0]   ana_q, ana_d;
  logic          fv_q, fv_d;
  logic          conn_q, conn_d;
  logic          sync1_q, sync2_q, prev_q;

  logic          w_fall;
  logic          w_good;
  logic [TW-1:0] w_timer_inc;
  logic [6:0]    w_bit_inc;

  assign w_fall      = prev_q & ~sync2_q;
  assign w_good      = (resp_q[63:61] == 3'b000) && resp_q[55];
  assign w_timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign w_bit_inc   = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 7'd1;

  always_comb begin
    state_d   = state_q;
    timer_d   = w_timer_inc;
    bit_cnt_d = bit_cnt_q;
    resp_d    = resp_q;
    cmd_d     = cmd_q;
    oe_d      = 1'b0;
    btn_d     = btn_q;
    ana_d     = ana_q;
    fv_d      = 1'b0;
    conn_d    = conn_q;
    unique case (state_q)
      IDLE: begin
        if (timer_q == POLL_END) begin
          state_d   = SEND;
          timer_d   = '0;
          bit_cnt_d = '0;
          cmd_d     = POLL_CMD;
        end
      end
      SEND: begin
        // Pulse width encodes the bit: short low for '1', long low for '0'
        oe_d = (timer_q < (cmd_q[24] ? ONE_LOW : ZERO_LOW));
        if (timer_q == BIT_END) begin
          timer_d = '0;
          cmd_d   = {cmd_q[23:0], 1'b0};
          if (bit_cnt_q == SEND_LAST) begin
            state_d   = WAIT_RESP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = w_bit_inc;
          end
        end
      end
      WAIT_RESP: begin
        if (w_fall) begin
          state_d   = RECV;
          timer_d   = '0;
          bit_cnt_d = '0;
        end else if (timer_q == TMO_END) begin
          state_d = IDLE;
          timer_d = '0;
          conn_d  = 1'b0;
        end
      end
      RECV: begin
        if (w_fall) begin
          timer_d = '0;
        end else if (timer_q == SAMPLE_AT) begin
          resp_d    = {resp_q[62:0], sync2_q};
          bit_cnt_d = w_bit_inc;
          if (bit_cnt_q == RECV_LAST) begin
            state_d = CHECK;
          end
        end else if (timer_q == WDOG_END) begin
          state_d = IDLE;
          timer_d = '0;
          conn_d  = 1'b0;
        end
      end
      CHECK: begin
        state_d = IDLE;
        timer_d = '0;
        if (w_good) begin
          btn_d  = {resp_q[60:56], resp_q[54:48]};
          ana_d  = resp_q[47:0];
          fv_d   = 1'b1;
          conn_d = 1'b1;
        end else begin
          conn_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      resp_q    <= '0;
      cmd_q     <= '0;
      oe_q      <= 1'b0;
      btn_q     <= '0;
      ana_q     <= '0;
      fv_q      <= 1'b0;
      conn_q    <= 1'b0;
      // Idle line is pulled high; resetting high avoids a phantom falling edge
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      resp_q    <= resp_d;
      cmd_q     <= cmd_d;
      oe_q      <= oe_d;
      btn_q     <= btn_d;
      ana_q     <= ana_d;
      fv_q      <= fv_d;
      conn_q    <= conn_d;
      sync1_q   <= bus.data_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  assign bus.data_oe     = oe_q;
  assign bus.frame_valid = fv_q;
  assign bus.connected   = conn_q;
  assign {bus.start_pause, bus.Y, bus.X, bus.B, bus.A,
          bus.L, bus.R, bus.Z, bus.D_UP, bus.D_DOWN, bus.D_RIGHT, bus.D_LEFT} = btn_q;
  assign {bus.stick_x, bus.stick_y, bus.cstick_x, bus.cstick_y,
          bus.trig_l, bus.trig_r} = ana_q;
endmodule
`default_nettype wire
